// File: rtl/ctrl_byte_arbiter_pkg.sv
// Shared types and constants for the two-source command byte arbiter.
package ctrl_byte_arbiter_pkg;

  // Arbiter FSM encodings
  typedef enum logic [1:0] {
    ARB_STATE_IDLE   = 2'd0,
    ARB_STATE_LOCKED = 2'd1,
    ARB_STATE_ABORT  = 2'd2
  } arb_state_e;

  // Controller state codes this block reacts to; must match the controller build
  localparam logic [7:0] CONTROLLER_STATE_READY = 8'h00;
  localparam logic [7:0] CONTROLLER_STATE_BEGIN = 8'h01;

  localparam logic OWNER_A = 1'b0;
  localparam logic OWNER_B = 1'b1;

  // Grant the only pending source; if both are pending, alternate away from the last owner
  function automatic logic pick_owner(input logic a_pending, input logic b_pending,
                                      input logic last_owner);
    if (a_pending && b_pending) begin
      return ~last_owner;
    end
    return b_pending;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Small synchronous FIFO with combinational head, flush and overflow pulse.
module byte_fifo #(
  parameter int depth = 16,
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [width-1:0] din,
  input  logic             pop,
  input  logic             flush,
  output logic [width-1:0] head,
  output logic             empty,
  output logic             full,
  output logic             overflow
);

  localparam int AW = $clog2(depth);

  logic [width-1:0] mem [depth];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             do_push;
  logic             do_pop;

  assign full     = (count_q == (AW+1)'(depth));
  assign empty    = (count_q == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign head     = mem[rd_ptr_q];
  assign overflow = overflow_q;

  // Pointer/count update; a flush keeps only a byte arriving in the same cycle
  always_comb begin
    wr_ptr_d   = wr_ptr_q + AW'(do_push);
    rd_ptr_d   = rd_ptr_q + AW'(do_pop);
    count_d    = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    overflow_d = push && full;
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = (AW+1)'(do_push);
    end
  end

  // Storage array has no reset so it maps onto plain memory
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= din;
    end
  end

  // Control state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: rtl/ctrl_byte_arbiter.sv
// Packet-level arbiter sharing one command controller between sources A and B,
// with a stall watchdog that aborts a packet whose owner stops sending.
module ctrl_byte_arbiter
  import ctrl_byte_arbiter_pkg::*;
#(
  parameter int fifo_depth     = 16,
  parameter int timeout_cycles = 65535
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] a_byte,
  input  logic       a_valid,
  output logic       a_ready,
  input  logic [7:0] b_byte,
  input  logic       b_valid,
  output logic       b_ready,
  output logic [7:0] out_byte,
  output logic       out_ready,
  input  logic       next,
  input  logic [7:0] control_state,
  output logic       owner,
  output logic       busy,
  output logic       ctrl_abort,
  output logic       timeout,
  output logic       a_overflow,
  output logic       b_overflow
);

  localparam int STALL_W = $clog2(timeout_cycles + 1);

  arb_state_e         state_q, state_d;
  logic               owner_q, owner_d;
  logic               last_owner_q, last_owner_d;
  logic               left_ready_q, left_ready_d;
  logic [STALL_W-1:0] stall_ctr_q, stall_ctr_d;
  logic               ctrl_abort_q, ctrl_abort_d;
  logic               timeout_q, timeout_d;

  logic [7:0] a_head, b_head;
  logic       a_empty, b_empty, a_full, b_full;
  logic       locked, owner_empty, starved, ctrl_ready;
  logic       pop_a, pop_b, flush_a, flush_b;

  assign locked      = (state_q == ARB_STATE_LOCKED);
  assign ctrl_ready  = (control_state == CONTROLLER_STATE_READY);
  assign owner_empty = (owner_q == OWNER_B) ? b_empty : a_empty;
  assign starved     = owner_empty && left_ready_q;

  // Only the owner FIFO is ever popped or flushed; the other keeps filling
  assign pop_a   = locked && next && (owner_q == OWNER_A);
  assign pop_b   = locked && next && (owner_q == OWNER_B);
  assign flush_a = (state_q == ARB_STATE_ABORT) && (owner_q == OWNER_A);
  assign flush_b = (state_q == ARB_STATE_ABORT) && (owner_q == OWNER_B);

  byte_fifo #(.depth(fifo_depth), .width(8)) u_fifo_a (
    .clk      (clk),
    .reset    (reset),
    .push     (a_valid),
    .din      (a_byte),
    .pop      (pop_a),
    .flush    (flush_a),
    .head     (a_head),
    .empty    (a_empty),
    .full     (a_full),
    .overflow (a_overflow)
  );

  byte_fifo #(.depth(fifo_depth), .width(8)) u_fifo_b (
    .clk      (clk),
    .reset    (reset),
    .push     (b_valid),
    .din      (b_byte),
    .pop      (pop_b),
    .flush    (flush_b),
    .head     (b_head),
    .empty    (b_empty),
    .full     (b_full),
    .overflow (b_overflow)
  );

  assign a_ready    = !a_full;
  assign b_ready    = !b_full;
  assign busy       = (state_q != ARB_STATE_IDLE);
  assign owner      = busy && owner_q;
  assign out_ready  = locked && !owner_empty;
  assign out_byte   = locked ? ((owner_q == OWNER_B) ? b_head : a_head) : 8'h00;
  assign ctrl_abort = ctrl_abort_q;
  assign timeout    = timeout_q;

  // Next-state logic: grant on READY, release after the controller leaves and returns to READY
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    left_ready_d = left_ready_q;
    stall_ctr_d  = stall_ctr_q;
    ctrl_abort_d = 1'b0;
    timeout_d    = 1'b0;
    case (state_q)
      ARB_STATE_IDLE: begin
        left_ready_d = 1'b0;
        stall_ctr_d  = '0;
        if (ctrl_ready && (!a_empty || !b_empty)) begin
          state_d = ARB_STATE_LOCKED;
          owner_d = pick_owner(!a_empty, !b_empty, last_owner_q);
        end
      end
      ARB_STATE_LOCKED: begin
        if (!ctrl_ready) begin
          left_ready_d = 1'b1;
        end
        if (left_ready_q && ctrl_ready) begin
          state_d      = ARB_STATE_IDLE;
          last_owner_d = owner_q;
        end else if (starved && (stall_ctr_q == STALL_W'(timeout_cycles - 1))) begin
          state_d      = ARB_STATE_ABORT;
          ctrl_abort_d = 1'b1;
          timeout_d    = 1'b1;
        end else begin
          stall_ctr_d = starved ? (stall_ctr_q + STALL_W'(1)) : '0;
        end
      end
      ARB_STATE_ABORT: begin
        state_d      = ARB_STATE_IDLE;
        last_owner_d = owner_q;
      end
      default: begin
        state_d = ARB_STATE_IDLE;
      end
    endcase
  end

  // FSM and registered pulse outputs; last_owner resets to B so A wins first
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ARB_STATE_IDLE;
      owner_q      <= OWNER_A;
      last_owner_q <= OWNER_B;
      left_ready_q <= 1'b0;
      stall_ctr_q  <= '0;
      ctrl_abort_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      left_ready_q <= left_ready_d;
      stall_ctr_q  <= stall_ctr_d;
      ctrl_abort_q <= ctrl_abort_d;
      timeout_q    <= timeout_d;
    end
  end

endmodule

// File: tb/tb_ctrl_byte_arbiter.sv
// Directed bench for ctrl_byte_arbiter with per-source scoreboards.
module tb_ctrl_byte_arbiter;
  import ctrl_byte_arbiter_pkg::*;

  localparam int DEPTH = 16;
  localparam int TMO   = 8;

  logic       clk, reset;
  logic [7:0] a_byte, b_byte, out_byte, control_state;
  logic       a_valid, a_ready, b_valid, b_ready, out_ready, next;
  logic       owner, busy, ctrl_abort, timeout, a_overflow, b_overflow;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  logic [7:0] sb_a[$];
  logic [7:0] sb_b[$];

  ctrl_byte_arbiter #(.fifo_depth(DEPTH), .timeout_cycles(TMO)) dut (
    .clk           (clk),
    .reset         (reset),
    .a_byte        (a_byte),
    .a_valid       (a_valid),
    .a_ready       (a_ready),
    .b_byte        (b_byte),
    .b_valid       (b_valid),
    .b_ready       (b_ready),
    .out_byte      (out_byte),
    .out_ready     (out_ready),
    .next          (next),
    .control_state (control_state),
    .owner         (owner),
    .busy          (busy),
    .ctrl_abort    (ctrl_abort),
    .timeout       (timeout),
    .a_overflow    (a_overflow),
    .b_overflow    (b_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    a_valid = 1'b0; b_valid = 1'b0; a_byte = 8'h00; b_byte = 8'h00;
    next = 1'b0; control_state = CONTROLLER_STATE_READY;
    step();
    step();
    reset = 1'b0;
    sb_a.delete();
    sb_b.delete();
  endtask

  // One push cycle; the scoreboard occupancy decides whether the byte is expected to land
  task automatic push(input logic va, input logic [7:0] da, input logic vb, input logic [7:0] db);
    a_valid = va; a_byte = da; b_valid = vb; b_byte = db;
    if (va && sb_a.size() < DEPTH) sb_a.push_back(da);
    if (vb && sb_b.size() < DEPTH) sb_b.push_back(db);
    step();
    a_valid = 1'b0; b_valid = 1'b0;
  endtask

  task automatic wait_grant(input logic exp_owner, input string tag);
    int guard;
    guard = 0;
    while (out_ready !== 1'b1 && guard < 40) begin
      step();
      guard++;
    end
    check({tag, "_grant"}, out_ready, 1);
    check({tag, "_owner"}, owner, exp_owner);
    check({tag, "_busy"}, busy, 1);
  endtask

  function automatic logic [7:0] pop_expected(input logic src);
    logic [7:0] v;
    v = 8'hxx;
    if (src == OWNER_B) begin
      if (sb_b.size() > 0) v = sb_b.pop_front();
    end else begin
      if (sb_a.size() > 0) v = sb_a.pop_front();
    end
    return v;
  endfunction

  // Acts as the controller: consume n bytes, leave READY, return to READY at packet end
  task automatic serve(input int n, input logic exp_owner, input string tag);
    logic [7:0] exp_b;
    wait_grant(exp_owner, tag);
    for (int i = 0; i < n; i++) begin
      exp_b = pop_expected(exp_owner);
      check($sformatf("%s_byte%0d", tag, i), out_byte, exp_b);
      $display("tb: %s owner=%0d byte%0d=%02h", tag, owner, i, out_byte);
      next = 1'b1;
      step();
      next = 1'b0;
      control_state = CONTROLLER_STATE_BEGIN;
      step();
    end
    control_state = CONTROLLER_STATE_READY;
    step();
    check({tag, "_release"}, busy, 0);
  endtask

  initial begin
    logic [7:0] exp_b;
    logic       seen;

    // Reset state
    do_reset();
    check("rst_out_ready", out_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_owner", owner, 0);
    check("rst_out_byte", out_byte, 0);
    check("rst_a_ready", a_ready, 1);
    check("rst_b_ready", b_ready, 1);
    check("rst_abort", ctrl_abort, 0);
    check("rst_timeout", timeout, 0);
    check("rst_ovf", {a_overflow, b_overflow}, 0);

    // Five-byte write-reg packet from A, including grant latency
    push(1'b1, 8'h01, 1'b0, 8'h00);
    check("t1_lat_t1", out_ready, 0);
    push(1'b1, 8'h03, 1'b0, 8'h00);
    check("t1_lat_t2", out_ready, 1);
    push(1'b1, 8'h05, 1'b0, 8'h00);
    push(1'b1, 8'h00, 1'b0, 8'h00);
    push(1'b1, 8'h10, 1'b0, 8'h00);
    serve(5, OWNER_A, "t1");
    step();
    step();
    check("t1_a_empty", busy, 0);

    // Simultaneous 2-byte packets from A and B: A first, then B
    do_reset();
    push(1'b1, 8'h11, 1'b1, 8'h21);
    push(1'b1, 8'h12, 1'b1, 8'h22);
    serve(2, OWNER_A, "t2a");
    serve(2, OWNER_B, "t2b");

    // Overflow: 17 bytes into a 16-deep FIFO with no consumption
    do_reset();
    for (int i = 0; i < DEPTH; i++) push(1'b1, 8'h40 + 8'(i), 1'b0, 8'h00);
    check("t3_a_ready_full", a_ready, 0);
    check("t3_no_ovf_yet", a_overflow, 0);
    push(1'b1, 8'hEE, 1'b0, 8'h00);
    check("t3_ovf_pulse", a_overflow, 1);
    step();
    check("t3_ovf_once", a_overflow, 0);
    serve(DEPTH, OWNER_A, "t3");
    check("t3_a_ready_again", a_ready, 1);
    step();
    step();
    check("t3_17th_dropped", busy, 0);

    // Watchdog: A sends only the command byte, B has a pending packet
    do_reset();
    push(1'b1, 8'h01, 1'b1, 8'h31);
    wait_grant(OWNER_A, "t4a");
    exp_b = pop_expected(OWNER_A);
    check("t4_cmd_byte", out_byte, exp_b);
    next = 1'b1;
    step();
    next = 1'b0;
    control_state = CONTROLLER_STATE_BEGIN;
    seen = 1'b0;
    for (int i = 0; i < TMO; i++) begin
      step();
      seen = seen | timeout | ctrl_abort;
    end
    check("t4_no_early_timeout", seen, 0);
    step();
    check("t4_timeout", timeout, 1);
    check("t4_ctrl_abort", ctrl_abort, 1);
    check("t4_busy_abort", busy, 1);
    control_state = CONTROLLER_STATE_READY;
    step();
    check("t4_timeout_1cyc", timeout, 0);
    check("t4_abort_1cyc", ctrl_abort, 0);
    check("t4_idle", busy, 0);
    serve(1, OWNER_B, "t4b");

    // Asynchronous reset in the middle of a packet
    do_reset();
    push(1'b1, 8'h81, 1'b1, 8'h91);
    push(1'b1, 8'h82, 1'b0, 8'h00);
    wait_grant(OWNER_A, "t5");
    next = 1'b1;
    step();
    next = 1'b0;
    control_state = CONTROLLER_STATE_BEGIN;
    #3;
    reset = 1'b1;
    #1;
    check("t5_out_ready", out_ready, 0);
    check("t5_busy", busy, 0);
    check("t5_owner", owner, 0);
    check("t5_abort", ctrl_abort, 0);
    step();
    reset = 1'b0;
    control_state = CONTROLLER_STATE_READY;
    sb_a.delete();
    sb_b.delete();
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      seen = seen | busy | out_ready | ctrl_abort;
    end
    check("t5_fifos_empty", seen, 0);

    // Single-byte invalid command; last_owner update drives the next round-robin grant
    do_reset();
    push(1'b1, 8'hFF, 1'b0, 8'h00);
    serve(1, OWNER_A, "t6a");
    push(1'b1, 8'h61, 1'b1, 8'h71);
    serve(1, OWNER_B, "t6b");
    serve(1, OWNER_A, "t6c");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
